// File: rtl/usb_rx_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_bit_decoder
// Description : USB receive front end. Synchronises D+/D-, flags transitions
//               and SE0 (EOP), times the per-bit sample strobe, NRZI-decodes
//               the line, drops stuffed bits and assembles bytes LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int EDGE_RELOAD  = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_in,
  input  logic       d_minus_in,
  input  logic       rcving,
  output logic       d_edge,
  output logic       eop,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [3:0] bit_count,
  output logic [7:0] rcv_data
);

  localparam int            TW            = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] C_TIMER_MAX   = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] C_SAMPLE_PT   = TW'(SAMPLE_POINT);
  localparam logic [TW-1:0] C_EDGE_RELOAD = TW'(EDGE_RELOAD);
  localparam logic [2:0]    C_STUFF_RUN   = 3'd6;

  logic          r_dp_meta;
  logic          r_dp_s;
  logic          r_dm_meta;
  logic          r_dm_s;
  logic          r_dp_last;
  logic [TW-1:0] r_timer;
  logic          r_nrzi_prev;
  logic [2:0]    r_ones;

  logic          w_bit;
  logic          w_stuffed;
  logic [3:0]    w_next_count;

  // Two-flop synchronisers; reset to the idle J state (D+ high, D- low).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dp_meta <= 1'b1;
      r_dp_s    <= 1'b1;
      r_dm_meta <= 1'b0;
      r_dm_s    <= 1'b0;
    end else begin
      r_dp_meta <= d_plus_in;
      r_dp_s    <= r_dp_meta;
      r_dm_meta <= d_minus_in;
      r_dm_s    <= r_dm_meta;
    end
  end

  // Line events: transition on synchronised D+ and SE0 level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dp_last <= 1'b1;
      d_edge    <= 1'b0;
      eop       <= 1'b0;
    end else begin
      r_dp_last <= r_dp_s;
      d_edge    <= r_dp_s ^ r_dp_last;
      eop       <= ~r_dp_s & ~r_dm_s;
    end
  end

  // Bit timer: free-runs 1..CLKS_PER_BIT while receiving, re-phased by edges.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_timer      <= '0;
      shift_enable <= 1'b0;
    end else begin
      shift_enable <= rcving && (r_timer == C_SAMPLE_PT);
      if (!rcving) begin
        r_timer <= '0;
      end else if (d_edge) begin
        r_timer <= C_EDGE_RELOAD;
      end else if (r_timer == C_TIMER_MAX) begin
        r_timer <= TW'(1);
      end else begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  // NRZI: an unchanged level is a 1; six 1s in a row mean the next bit is stuffing.
  always_comb begin
    w_bit        = (r_dp_s == r_nrzi_prev);
    w_stuffed    = (r_ones == C_STUFF_RUN);
    w_next_count = (bit_count == 4'd8) ? 4'd1 : bit_count + 4'd1;
  end

  // Byte assembly on each sample strobe; SE0 samples only advance the count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_count     <= 4'd0;
      rcv_data      <= 8'h00;
      r_ones        <= 3'd0;
      r_nrzi_prev   <= 1'b1;
      byte_received <= 1'b0;
    end else begin
      byte_received <= 1'b0;
      if (!rcving) begin
        bit_count   <= 4'd0;
        r_ones      <= 3'd0;
        r_nrzi_prev <= 1'b1;
      end else if (shift_enable) begin
        r_nrzi_prev <= r_dp_s;
        if (eop) begin
          r_ones    <= 3'd0;
          bit_count <= w_next_count;
        end else if (w_stuffed) begin
          r_ones <= 3'd0;
        end else begin
          rcv_data      <= {w_bit, rcv_data[7:1]};
          r_ones        <= w_bit ? r_ones + 3'd1 : 3'd0;
          bit_count     <= w_next_count;
          byte_received <= (w_next_count == 4'd8);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_bit_decoder
// Description : Self-checking bench for usb_rx_bit_decoder. Packets are built
//               from data bytes, bit-stuffed and NRZI-encoded by the bench;
//               expected bytes go to a queue popped by an output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_bit_decoder;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_plus = 1'b1;
  logic       d_minus = 1'b0;
  logic       rcving = 1'b0;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [3:0] bit_count;
  logic [7:0] rcv_data;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         se_cnt = 0;
  bit         eop_armed = 1'b0;
  bit         eop_pending = 1'b0;
  logic [3:0] eop_exp_bc = 4'd0;

  always #5 clk = ~clk;

  usb_rx_bit_decoder #(
    .CLKS_PER_BIT(8),
    .SAMPLE_POINT(3),
    .EDGE_RELOAD (2)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus_in    (d_plus),
    .d_minus_in   (d_minus),
    .rcving       (rcving),
    .d_edge       (d_edge),
    .eop          (eop),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .bit_count    (bit_count),
    .rcv_data     (rcv_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Output monitor: counts strobes, checks delivered bytes and bit_count under EOP.
  always @(negedge clk) begin
    logic [7:0] e;
    if (n_rst) begin
      if (shift_enable) se_cnt++;
      if (eop_pending) begin
        check("eop_bit_count", bit_count, eop_exp_bc);
        eop_pending = 1'b0;
      end
      if (shift_enable && eop && eop_armed) begin
        eop_pending = 1'b1;
        eop_armed   = 1'b0;
      end
      if (byte_received) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte_received", byte_received, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rcv_data", rcv_data, e);
          check("bit_count_at_byte", bit_count, 4'd8);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line_bit(input bit lvl);
    d_plus  = lvl;
    d_minus = ~lvl;
    tick(8);
  endtask

  // First bit of a packet: the controller raises rcving shortly after the edge.
  task automatic first_bit(input bit lvl);
    d_plus  = lvl;
    d_minus = ~lvl;
    tick(2);
    rcving = 1'b1;
    tick(6);
  endtask

  // SYNC + nbytes whole bytes + extra loose bits, then EOP (or abort mid-byte).
  task automatic send_packet(input int nbytes, input logic [7:0] first,
                             input bit use_first, input int extra, input bit abort_mid);
    bit         dbits[$];
    bit         lbits[$];
    int         ones;
    bit         lvl;
    int         r;
    logic [7:0] v;
    for (int i = 0; i < 8; i++) dbits.push_back(i == 7);
    exp_q.push_back(8'h80);
    for (int b = 0; b < nbytes; b++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 3) == 0) v = 8'hFF;
      if (b == 0 && use_first) v = first;
      for (int i = 0; i < 8; i++) dbits.push_back(v[i]);
      exp_q.push_back(v);
    end
    for (int i = 0; i < extra; i++) dbits.push_back(1'($urandom));
    ones = 0;
    foreach (dbits[i]) begin
      lbits.push_back(dbits[i]);
      ones = dbits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lbits.push_back(1'b0);
        ones = 0;
      end
    end
    se_cnt = 0;
    lvl = 1'b1;
    foreach (lbits[i]) begin
      if (!lbits[i]) lvl = ~lvl;
      if (i == 0) first_bit(lvl);
      else line_bit(lvl);
    end
    if (abort_mid) begin
      rcving = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_bit_count", bit_count, 4'd0);
      check("abort_shift_count", se_cnt, lbits.size());
      d_plus  = 1'b1;
      d_minus = 1'b0;
      tick(24);
    end else begin
      r          = dbits.size() % 8;
      eop_exp_bc = (r == 0) ? 4'd1 : 4'(r + 1);
      eop_armed  = 1'b1;
      d_plus     = 1'b0;
      d_minus    = 1'b0;
      tick(16);
      rcving = 1'b0;
      check("shift_count", se_cnt, lbits.size() + 2);
      d_plus  = 1'b1;
      d_minus = 1'b0;
      tick(24);
      check("eop_strobe_seen", eop_armed, 1'b0);
      check("post_packet_bit_count", bit_count, 4'd0);
      check("post_packet_eop", eop, 1'b0);
    end
  endtask

  // Reset asserted partway through a SYNC byte.
  task automatic reset_mid_packet();
    first_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    tick(3);
    check("pre_reset_bit_count", bit_count, 4'd3);
    #2 n_rst = 1'b0;
    #1 check("reset_outputs", {d_edge, eop, shift_enable, byte_received, bit_count, rcv_data}, 16'h0);
    rcving  = 1'b0;
    d_plus  = 1'b1;
    d_minus = 1'b0;
    tick(4);
    n_rst = 1'b1;
    tick(16);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    n_rst = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("idle_outputs", {d_edge, eop, shift_enable, byte_received, bit_count, rcv_data}, 16'h0);
    end
    tick(1);
    send_packet(1, 8'hA5, 1'b1, 0, 1'b0);
    send_packet(1, 8'hFF, 1'b1, 0, 1'b0);
    send_packet(2, 8'h00, 1'b0, 0, 1'b0);
    send_packet(1, 8'h00, 1'b0, 3, 1'b0);
    send_packet(0, 8'h00, 1'b0, 5, 1'b1);
    reset_mid_packet();
    for (int p = 0; p < 14; p++) begin
      if ($urandom_range(0, 4) == 0)
        send_packet($urandom_range(0, 2), 8'h00, 1'b0, $urandom_range(1, 7), 1'b1);
      else
        send_packet($urandom_range(1, 3), 8'h00, 1'b0, $urandom_range(0, 7), 1'b0);
    end
    tick(8);
    check("pending_bytes", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
